// File: rtl/core_pkg.sv
// Shared core types: ALU control, instruction/decoder types and nibble-count encodings.
package core_pkg;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR
   } alu_op_e;

   typedef struct packed {
      alu_op_e op;
      logic    carry_in;
   } AluCtrl;

   typedef enum logic [3:0] {
      OPC_ADD,
      OPC_SUB,
      OPC_AND,
      OPC_OR,
      OPC_XOR,
      OPC_ADDI,
      OPC_LOAD,
      OPC_STORE,
      OPC_BRANCH,
      OPC_JUMP
   } OpCode;

   typedef logic [3:0] RegAddr;

   typedef struct packed {
      OpCode       opcode;
      RegAddr      rd;
      RegAddr      rs1;
      RegAddr      rs2;
      logic [11:0] imm;
      logic [3:0]  rsvd;
   } Instruction;

   typedef struct packed {
      AluCtrl     ctrl;
      logic [2:0] nibbles_number;
      logic       imm_is_negative;
      RegAddr     rd;
   } DecodedAluCmd;

   // Index of the last mandatory nibble for each operand width.
   localparam logic [2:0] NIBBLES_INC = 3'd0;
   localparam logic [2:0] NIBBLES_8B  = 3'd1;
   localparam logic [2:0] NIBBLES_12B = 3'd2;
   localparam logic [2:0] NIBBLES_16B = 3'd3;
   localparam logic [2:0] NIBBLES_32B = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } loop_state_e;

endpackage

// File: rtl/loop_over_all_nibbles_nibble_alu.sv
// Combinational 4-bit ALU slice with carry in/out; logic ops always produce carry-out 0.
module nibble_alu
   import core_pkg::*;
(
   input  alu_op_e    op,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       carry_in,
   output logic [3:0] y,
   output logic       carry_out
);

   logic [3:0] b_eff;
   logic [4:0] sum;

   // Subtraction is a + ~b + c; the caller supplies carry_in = 1.
   assign b_eff = (op == ALU_SUB) ? ~b : b;
   assign sum   = {1'b0, a} + {1'b0, b_eff} + {4'b0000, carry_in};

   always_comb begin
      y         = 4'h0;
      carry_out = 1'b0;
      case (op)
         ALU_ADD, ALU_SUB: begin
            y         = sum[3:0];
            carry_out = sum[4];
         end
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_XOR: y = a ^ b;
         default: y = 4'h0;
      endcase
   end

endmodule

// File: rtl/loop_over_all_nibbles.sv
// Nibble-serial 32-bit ALU, one nibble per clock with carry chaining between nibbles.
// Define NIBBLE_LOOP_EARLY_EXIT_EN to stop after nibble N once no carry or sign fill remains.
module loop_over_all_nibbles
   import core_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        loop_perm_to_count,
   input  AluCtrl      ctrl,
   input  logic [2:0]  loop_nibbles_number,
   input  logic        word2_is_negative,
   input  logic [31:0] word1,
   input  logic [31:0] word2,
   input  logic [31:0] preinit_result,
   output logic [31:0] result,
   output logic        busy
);

   loop_state_e state_reg, state_next;
   logic [2:0]  curr_nibble_idx, curr_nibble_idx_next;
   logic        result_carry, result_carry_next;
   logic [31:0] result_next;
   logic        busy_int;

   logic [3:0]  w1_nib [8];
   logic [3:0]  w2_nib [8];

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_nib
         assign w1_nib[gi] = word1[gi*4 +: 4];
         assign w2_nib[gi] = word2[gi*4 +: 4];
      end
   endgenerate

   // IDLE works on nibble 0 with the caller's carry; RUN uses the saved index/carry.
   logic [2:0] work_idx;
   logic       work_carry;
   logic [3:0] nib_a, nib_b, nib_y;
   logic       nib_cout;
   logic       finish;

   assign work_idx   = (state_reg == ST_RUN) ? curr_nibble_idx : 3'd0;
   assign work_carry = (state_reg == ST_RUN) ? result_carry : ctrl.carry_in;
   assign nib_a      = w1_nib[work_idx];
   assign nib_b      = (work_idx > loop_nibbles_number) ? {4{word2_is_negative}}
                                                        : w2_nib[work_idx];

   nibble_alu u_nibble_alu (
      .op        (ctrl.op),
      .a         (nib_a),
      .b         (nib_b),
      .carry_in  (work_carry),
      .y         (nib_y),
      .carry_out (nib_cout)
   );

`ifdef NIBBLE_LOOP_EARLY_EXIT_EN
   assign finish = (work_idx == 3'd7) ||
                   ((work_idx >= loop_nibbles_number) && !nib_cout && !word2_is_negative);
`else
   assign finish = (work_idx == 3'd7);
`endif

   always_comb begin
      state_next           = state_reg;
      curr_nibble_idx_next = curr_nibble_idx;
      result_carry_next    = result_carry;
      result_next          = result;
      busy_int             = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            busy_int = loop_perm_to_count;
            if (loop_perm_to_count) begin
               result_next                       = preinit_result;
               result_next[{work_idx, 2'b00} +: 4] = nib_y;
               result_carry_next                 = nib_cout;
               curr_nibble_idx_next              = 3'd1;
               state_next                        = finish ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            busy_int = 1'b1;
            if (!loop_perm_to_count) begin
               state_next = ST_IDLE;
            end else begin
               result_next[{work_idx, 2'b00} +: 4] = nib_y;
               result_carry_next                 = nib_cout;
               curr_nibble_idx_next              = curr_nibble_idx + 3'd1;
               state_next                        = finish ? ST_DONE : ST_RUN;
            end
         end
         ST_DONE: begin
            if (!loop_perm_to_count) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Reset forces busy low even though IDLE would otherwise mirror the request.
   assign busy = rst_n & busy_int;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         curr_nibble_idx <= 3'd0;
         result_carry    <= 1'b0;
         result          <= 32'h0;
      end else begin
         state_reg       <= state_next;
         curr_nibble_idx <= curr_nibble_idx_next;
         result_carry    <= result_carry_next;
         result          <= result_next;
      end
   end

endmodule

// File: tb/tb_loop_over_all_nibbles.sv
// Scoreboard bench for loop_over_all_nibbles: stimulus queues expected results, a monitor checks them.
module tb_loop_over_all_nibbles;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        perm = 1'b0;
   AluCtrl      ctrl;
   logic [2:0]  nsel;
   logic        neg;
   logic [31:0] w1, w2, pre;
   logic [31:0] result;
   logic        busy;

`ifdef NIBBLE_LOOP_EARLY_EXIT_EN
   localparam int PC_CYC   = 3;
   localparam int ADDI_CYC = 3;
`else
   localparam int PC_CYC   = 8;
   localparam int ADDI_CYC = 8;
`endif

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   busy_cnt = 0;

   always #5 clk = ~clk;

   loop_over_all_nibbles dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .loop_perm_to_count  (perm),
      .ctrl                (ctrl),
      .loop_nibbles_number (nsel),
      .word2_is_negative   (neg),
      .word1               (w1),
      .word2               (w2),
      .preinit_result      (pre),
      .result              (result),
      .busy                (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Monitor: a busy->idle transition outside reset marks a completed operation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy_cnt = 0;
         end else if (busy) begin
            busy_cnt++;
         end else if (busy_cnt > 0) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done: got result %h with nothing expected", result);
            end else begin
               e = exp_q.pop_front();
               $display("done: result=%h busy_cycles=%0d (expected %h / %0d)",
                        result, busy_cnt, e.res, e.cyc);
               check("result", result, e.res);
               check("busy_cycles", busy_cnt, e.cyc);
            end
            busy_cnt = 0;
         end
      end
   end

   task automatic run_op(input alu_op_e op, input logic cin, input logic [2:0] n,
                         input logic ng, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] er, input int ec,
                         input int hold);
      exp_t e;
      bit   done;
      @(posedge clk);
      #1;
      ctrl.op       = op;
      ctrl.carry_in = cin;
      nsel = n;
      neg  = ng;
      w1   = a;
      w2   = b;
      pre  = p;
      e.res = er;
      e.cyc = ec;
      exp_q.push_back(e);
      perm = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (!busy) done = 1'b1;
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout: busy still %b, expected low within 20 cycles", busy);
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         check("hold_busy", busy, 32'h0);
         check("hold_result", result, er);
      end
      @(posedge clk);
      #1;
      perm = 1'b0;
   endtask

   initial begin
      ctrl = '0;
      nsel = 3'd0;
      neg  = 1'b0;
      w1   = 32'h0;
      w2   = 32'h0;
      pre  = 32'h0;
      perm = 1'b1;
      #1;
      check("reset_busy", busy, 32'h0);
      check("reset_result", result, 32'h0);
      @(posedge clk);
      #1;
      perm  = 1'b0;
      rst_n = 1'b1;

      run_op(ALU_ADD, 1'b0, 3'd0, 1'b0, 32'h000000FF, 32'h4, 32'h000000FF, 32'h00000103, PC_CYC, 0);
      run_op(ALU_ADD, 1'b0, 3'd2, 1'b0, 32'h0, 32'h07B, 32'h0, 32'h0000007B, ADDI_CYC, 3);
      run_op(ALU_ADD, 1'b0, 3'd2, 1'b0, 32'h7B, 32'h2, 32'h7B, 32'h0000007D, ADDI_CYC, 0);
      run_op(ALU_ADD, 1'b0, 3'd2, 1'b1, 32'h5, 32'hFFF, 32'h5, 32'h00000004, 8, 0);
      run_op(ALU_SUB, 1'b1, 3'd7, 1'b0, 32'd10, 32'd3, 32'd10, 32'h00000007, 8, 0);
      run_op(ALU_SUB, 1'b1, 3'd7, 1'b0, 32'h0, 32'h1, 32'h0, 32'hFFFFFFFF, 8, 0);
      run_op(ALU_AND, 1'b0, 3'd7, 1'b0, 32'hF0F01234, 32'h0FF0FF00, 32'hF0F01234, 32'h00F01200, 8, 0);
      run_op(ALU_XOR, 1'b0, 3'd7, 1'b0, 32'hF0F01234, 32'h0FF0FF00, 32'hF0F01234, 32'hFF00ED34, 8, 0);
      run_op(ALU_OR,  1'b0, 3'd7, 1'b0, 32'hF0F01234, 32'h0FF0FF00, 32'hF0F01234, 32'hFFF0FF34, 8, 0);

      // Reset in the middle of a full-width run.
      @(posedge clk);
      #1;
      ctrl.op = ALU_SUB;
      ctrl.carry_in = 1'b1;
      nsel = 3'd7;
      neg  = 1'b0;
      w1   = 32'h12345678;
      w2   = 32'h1;
      pre  = 32'h12345678;
      perm = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_run_busy", busy, 32'h1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_reset_busy", busy, 32'h0);
      check("mid_reset_result", result, 32'h0);
      @(posedge clk);
      #1;
      perm = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_op(ALU_ADD, 1'b0, 3'd0, 1'b0, 32'h000000FF, 32'h4, 32'h000000FF, 32'h00000103, PC_CYC, 0);

      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL missing_done: got %0d pending, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
